// File: rtl/reg_status_file_pkg.sv
// Shared sizes and the per-register rename status record for the
// architectural register file.
package reg_status_file_pkg;

    localparam int NUM_REGS  = 32;
    localparam int ROB_DEPTH = 8;
    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;
    localparam int ROB_TAG_W = $clog2(ROB_DEPTH);

    typedef struct packed {
        logic                 busy;
        logic [ROB_TAG_W-1:0] tag;
    } reg_status_t;

endpackage

// File: rtl/reg_status_file_if.sv
// Issue / read / commit / flush signals between the issue stage, ROB and the
// register file. master = issue+ROB side, slave = register file.
interface reg_status_file_if;
    import reg_status_file_pkg::*;

    logic                 issue_valid;
    logic [REG_IDX_W-1:0] issue_rd;
    logic [ROB_TAG_W-1:0] issue_tag;

    logic [REG_IDX_W-1:0] rs1_addr;
    logic [REG_IDX_W-1:0] rs2_addr;
    logic [XLEN-1:0]      rs1_value;
    logic [XLEN-1:0]      rs2_value;
    logic                 rs1_busy;
    logic                 rs2_busy;
    logic [ROB_TAG_W-1:0] rs1_tag;
    logic [ROB_TAG_W-1:0] rs2_tag;

    logic                 commit_valid;
    logic [REG_IDX_W-1:0] commit_rd;
    logic [ROB_TAG_W-1:0] commit_tag;
    logic [XLEN-1:0]      commit_data;

    logic                 flush;
    logic [ROB_DEPTH-1:0] invalidated_n;

    logic [NUM_REGS-1:0]  busy_vec;

    modport master (
        output issue_valid, issue_rd, issue_tag,
        output rs1_addr, rs2_addr,
        output commit_valid, commit_rd, commit_tag, commit_data,
        output flush, invalidated_n,
        input  rs1_value, rs2_value, rs1_busy, rs2_busy, rs1_tag, rs2_tag,
        input  busy_vec
    );

    modport slave (
        input  issue_valid, issue_rd, issue_tag,
        input  rs1_addr, rs2_addr,
        input  commit_valid, commit_rd, commit_tag, commit_data,
        input  flush, invalidated_n,
        output rs1_value, rs2_value, rs1_busy, rs2_busy, rs1_tag, rs2_tag,
        output busy_vec
    );

endinterface

// File: rtl/reg_status_file_read_port.sv
// One combinational source read: stored value/status, commit bypass for the
// matching producer, and the x0 override.
module reg_status_file_read_port
    import reg_status_file_pkg::*;
(
    input  logic [NUM_REGS-1:0][XLEN-1:0] values,
    input  reg_status_t [NUM_REGS-1:0]    status,
    input  logic [REG_IDX_W-1:0]          addr,
    input  logic                          commit_valid,
    input  logic [REG_IDX_W-1:0]          commit_rd,
    input  logic [ROB_TAG_W-1:0]          commit_tag,
    input  logic [XLEN-1:0]               commit_data,
    output logic [XLEN-1:0]               rd_value,
    output logic                          rd_busy,
    output logic [ROB_TAG_W-1:0]          rd_tag
);

    reg_status_t st;

    always_comb begin
        st       = status[addr];
        rd_value = values[addr];
        rd_busy  = st.busy;
        rd_tag   = st.busy ? st.tag : '0;
        // The producer is retiring this cycle: hand its result straight over.
        if (commit_valid && (commit_rd == addr) && st.busy && (st.tag == commit_tag)) begin
            rd_value = commit_data;
            rd_busy  = 1'b0;
            rd_tag   = '0;
        end
        if (addr == '0) begin
            rd_value = '0;
            rd_busy  = 1'b0;
            rd_tag   = '0;
        end
    end

endmodule

// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename status (busy + ROB tag),
// renamed at issue, retired at commit and scrubbed on branch flush.
module reg_status_file
    import reg_status_file_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    reg_status_file_if.slave  bus
);

    logic [NUM_REGS-1:0][XLEN-1:0] values_q;
    reg_status_t [NUM_REGS-1:0]    status_q;
    logic [NUM_REGS-1:0][XLEN-1:0] values_d;
    reg_status_t [NUM_REGS-1:0]    status_d;

    logic issue_hit;
    logic commit_hit;

    always_comb begin
        values_d   = values_q;
        status_d   = status_q;
        issue_hit  = 1'b0;
        commit_hit = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            issue_hit  = bus.issue_valid && !bus.flush && (bus.issue_rd == REG_IDX_W'(r));
            commit_hit = bus.commit_valid && (bus.commit_rd == REG_IDX_W'(r));
            if (commit_hit)
                values_d[r] = bus.commit_data;
            // A fresh rename owns rd even if an older writer retires now.
            if (issue_hit) begin
                status_d[r].busy = 1'b1;
                status_d[r].tag  = bus.issue_tag;
            end else if (bus.flush && status_q[r].busy && !bus.invalidated_n[status_q[r].tag]) begin
                status_d[r] = '0;
            end else if (commit_hit && status_q[r].busy && (status_q[r].tag == bus.commit_tag)) begin
                status_d[r] = '0;
            end
        end
        values_d[0] = '0;
        status_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            values_q <= '0;
            status_q <= '0;
        end else begin
            values_q <= values_d;
            status_q <= status_d;
        end
    end

    always_comb begin
        bus.busy_vec = '0;
        for (int r = 0; r < NUM_REGS; r++)
            bus.busy_vec[r] = status_q[r].busy;
    end

    reg_status_file_read_port u_rs1 (
        .values       (values_q),
        .status       (status_q),
        .addr         (bus.rs1_addr),
        .commit_valid (bus.commit_valid),
        .commit_rd    (bus.commit_rd),
        .commit_tag   (bus.commit_tag),
        .commit_data  (bus.commit_data),
        .rd_value     (bus.rs1_value),
        .rd_busy      (bus.rs1_busy),
        .rd_tag       (bus.rs1_tag)
    );

    reg_status_file_read_port u_rs2 (
        .values       (values_q),
        .status       (status_q),
        .addr         (bus.rs2_addr),
        .commit_valid (bus.commit_valid),
        .commit_rd    (bus.commit_rd),
        .commit_tag   (bus.commit_tag),
        .commit_data  (bus.commit_data),
        .rd_value     (bus.rs2_value),
        .rd_busy      (bus.rs2_busy),
        .rd_tag       (bus.rs2_tag)
    );

endmodule
